// File: rtl/top_pkg.sv
// Shared types and helpers for the attention datapath: chunk sizing, bank state
// encoding and the module-slice extractor used on the wide producer bus.
package top_pkg;

    localparam int TOP_CHUNK_SIZE = 1;
    localparam int TOP_BLOCK_SIZE = 32;
    localparam int MAX_BUS_W      = 4096;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    // Slice idx counts from the MSB end; callers zero-extend the bus to
    // MAX_BUS_W and truncate the result back to mod_w bits.
    function automatic logic [MAX_BUS_W-1:0] extract_module(
        input logic [MAX_BUS_W-1:0] bus,
        input int                   idx,
        input int                   mod_w,
        input int                   total
    );
        logic [MAX_BUS_W-1:0] mask;
        mask = {MAX_BUS_W{1'b1}} >> (MAX_BUS_W - mod_w);
        return (bus >> ((total - 1 - idx) * mod_w)) & mask;
    endfunction

endpackage

// File: rtl/pp_bank_ram.sv
// One bank of the ping-pong buffer: simple dual-port RAM, registered read,
// written behaviourally so a vendor macro can be dropped in.
module pp_bank_ram #(
    parameter  int DEPTH = 32,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/ping_pong_buffer_ctrl.sv
// Two-bank ping-pong buffer: fills one bank from a selected producer slice while
// the other is drained READ_PASSES times through a 2-entry output skid.
module ping_pong_buffer_ctrl
    import top_pkg::*;
#(
    parameter  int WIDTH         = 16,
    parameter  int NUM_CORES_A   = 2,
    parameter  int NUM_CORES_B   = 1,
    parameter  int TOTAL_MODULES = 4,
    parameter  int DEPTH         = 32,
    parameter  int READ_PASSES   = 2,
    localparam int MODULE_WIDTH  = WIDTH * TOP_CHUNK_SIZE * NUM_CORES_A * NUM_CORES_B,
    localparam int IN_WIDTH      = MODULE_WIDTH * TOTAL_MODULES,
    localparam int ADDR_WIDTH    = $clog2(DEPTH),
    localparam int SEL_W         = (TOTAL_MODULES > 1) ? $clog2(TOTAL_MODULES) : 1,
    localparam int PASS_W        = $clog2(READ_PASSES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic [SEL_W-1:0]        slicing_idx,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_WIDTH-1:0]     in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [MODULE_WIDTH-1:0] out_data,
    output logic                    out_last,
    output logic [PASS_W-1:0]       out_pass,
    output logic [1:0]              bank_full
);

    typedef struct packed {
        logic [MODULE_WIDTH-1:0] data;
        logic [PASS_W-1:0]       pass;
        logic                    last;
    } skid_t;

    bank_state_e             r_st [2];
    bank_state_e             w_st_nxt [2];
    logic                    r_wr_bank;
    logic                    r_iss_bank;
    logic                    r_rd_bank;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [ADDR_WIDTH-1:0]   r_rd_addr;
    logic [PASS_W-1:0]       r_pass;

    logic                    r_rd_vld;
    logic                    r_rd_last;
    logic                    r_rd_sel;
    logic [PASS_W-1:0]       r_rd_pass;

    skid_t                   r_sk0;
    skid_t                   r_sk1;
    logic [1:0]              r_sk_cnt;
    skid_t                   w_sk_in;

    logic [MAX_BUS_W-1:0]    w_bus_ext;
    logic [MODULE_WIDTH-1:0] w_wdata;
    logic [1:0][MODULE_WIDTH-1:0] w_ram_q;

    logic w_idx_ok;
    logic w_wr_fire;
    logic w_wr_en;
    logic w_wr_end;
    logic w_pop;
    logic w_release;
    logic w_room;
    logic w_rd_en;
    logic w_rd_wrap;
    logic w_rd_final;

    // ---------------- write side ----------------
    assign in_ready  = !clear && (r_st[r_wr_bank] == EMPTY || r_st[r_wr_bank] == FILLING);
    assign w_idx_ok  = int'(slicing_idx) < TOTAL_MODULES;
    assign w_wr_fire = in_valid && in_ready;
    assign w_wr_en   = w_wr_fire && w_idx_ok;
    assign w_wr_end  = w_wr_en && (r_wr_addr == ADDR_WIDTH'(DEPTH - 1));

    assign w_bus_ext = MAX_BUS_W'(in_data);
    assign w_wdata   = MODULE_WIDTH'(extract_module(w_bus_ext, int'(slicing_idx),
                                                    MODULE_WIDTH, TOTAL_MODULES));

    // ---------------- read side ----------------
    // Issue pointer runs ahead of the release pointer so the next bank starts
    // streaming while the tail of the previous one is still in the skid.
    assign out_valid  = (r_sk_cnt != 2'd0);
    assign w_pop      = out_valid && out_ready;
    assign w_release  = w_pop && r_sk0.last;
    assign w_room     = ({1'b0, r_sk_cnt} + 3'(r_rd_vld)) <= (3'd1 + 3'(w_pop));
    assign w_rd_en    = !clear && w_room &&
                        (r_st[r_iss_bank] == FULL || r_st[r_iss_bank] == DRAINING);
    assign w_rd_wrap  = (r_rd_addr == ADDR_WIDTH'(DEPTH - 1));
    assign w_rd_final = w_rd_wrap && (r_pass == PASS_W'(READ_PASSES - 1));

    // Write, issue and release always target different banks, so the three
    // updates never collide on one entry.
    always_comb begin
        w_st_nxt = r_st;
        if (w_wr_en)
            w_st_nxt[r_wr_bank] = w_wr_end ? FULL : FILLING;
        if (w_rd_en && r_st[r_iss_bank] == FULL)
            w_st_nxt[r_iss_bank] = DRAINING;
        if (w_release)
            w_st_nxt[r_rd_bank] = EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st[0]    <= EMPTY;
            r_st[1]    <= EMPTY;
            r_wr_bank  <= 1'b0;
            r_iss_bank <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_wr_addr  <= '0;
            r_rd_addr  <= '0;
            r_pass     <= '0;
            r_rd_vld   <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_sel   <= 1'b0;
            r_rd_pass  <= '0;
        end else if (clear) begin
            r_st[0]    <= EMPTY;
            r_st[1]    <= EMPTY;
            r_wr_bank  <= 1'b0;
            r_iss_bank <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_wr_addr  <= '0;
            r_rd_addr  <= '0;
            r_pass     <= '0;
            r_rd_vld   <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_sel   <= 1'b0;
            r_rd_pass  <= '0;
        end else begin
            r_st <= w_st_nxt;
            if (w_wr_en) begin
                if (w_wr_end) begin
                    r_wr_addr <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);
                end
            end
            if (w_rd_en) begin
                if (w_rd_wrap) begin
                    r_rd_addr <= '0;
                    if (w_rd_final) begin
                        r_pass     <= '0;
                        r_iss_bank <= ~r_iss_bank;
                    end else begin
                        r_pass <= r_pass + PASS_W'(1);
                    end
                end else begin
                    r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
                end
            end
            if (w_release) r_rd_bank <= ~r_rd_bank;
            r_rd_vld  <= w_rd_en;
            r_rd_last <= w_rd_en && w_rd_final;
            r_rd_pass <= r_pass;
            r_rd_sel  <= r_iss_bank;
        end
    end

    // ---------------- output skid ----------------
    assign w_sk_in = {w_ram_q[r_rd_sel], r_rd_pass, r_rd_last};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sk0    <= '0;
            r_sk1    <= '0;
            r_sk_cnt <= 2'd0;
        end else if (clear) begin
            r_sk0    <= '0;
            r_sk1    <= '0;
            r_sk_cnt <= 2'd0;
        end else begin
            case ({r_rd_vld, w_pop})
                2'b10: begin
                    if (r_sk_cnt == 2'd0) r_sk0 <= w_sk_in;
                    else                  r_sk1 <= w_sk_in;
                    r_sk_cnt <= r_sk_cnt + 2'd1;
                end
                2'b01: begin
                    r_sk0    <= r_sk1;
                    r_sk_cnt <= r_sk_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_sk_cnt == 2'd1) begin
                        r_sk0 <= w_sk_in;
                    end else begin
                        r_sk0 <= r_sk1;
                        r_sk1 <= w_sk_in;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data = r_sk0.data;
    assign out_pass = r_sk0.pass;
    assign out_last = r_sk0.last;

    // ---------------- banks ----------------
    for (genvar b = 0; b < 2; b++) begin : g_bank
        pp_bank_ram #(
            .DEPTH (DEPTH),
            .WIDTH (MODULE_WIDTH)
        ) u_ram (
            .clk     (clk),
            .i_we    (w_wr_en && (r_wr_bank == 1'(b))),
            .i_waddr (r_wr_addr),
            .i_wdata (w_wdata),
            .i_re    (w_rd_en && (r_iss_bank == 1'(b))),
            .i_raddr (r_rd_addr),
            .o_rdata (w_ram_q[b])
        );
        assign bank_full[b] = (r_st[b] == FULL) || (r_st[b] == DRAINING);
    end

    a_idx_range: assert property (@(posedge clk) disable iff (!rst_n)
        (in_valid && in_ready) |-> w_idx_ok);

    a_out_hold: assert property (@(posedge clk) disable iff (!rst_n || clear)
        (out_valid && !out_ready) |=> $stable({out_data, out_pass, out_last}));

endmodule

// File: tb/tb_ping_pong_buffer_ctrl.sv
// Directed bench for ping_pong_buffer_ctrl with a small fill/replay scoreboard.
module tb_ping_pong_buffer_ctrl;

    localparam int DEPTH = 4;
    localparam int RP    = 2;
    localparam int TM    = 4;
    localparam int MW    = 16 * top_pkg::TOP_CHUNK_SIZE * 2;
    localparam int IW    = MW * TM;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic [1:0]    slicing_idx = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [MW-1:0] out_data;
    logic          out_last;
    logic [1:0]    out_pass;
    logic [1:0]    bank_full;

    always #5 clk = ~clk;

    ping_pong_buffer_ctrl #(
        .WIDTH         (16),
        .NUM_CORES_A   (2),
        .NUM_CORES_B   (1),
        .TOTAL_MODULES (TM),
        .DEPTH         (DEPTH),
        .READ_PASSES   (RP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .slicing_idx (slicing_idx),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_pass    (out_pass),
        .bank_full   (bank_full)
    );

    typedef struct {
        logic [MW-1:0] d;
        int            p;
        bit            l;
    } exp_t;

    exp_t          q[$];
    logic [MW-1:0] fb[$];
    int            n_chk = 0;
    int            n_err = 0;
    int            pops  = 0;
    bit            stall = 0;
    logic [MW+2:0] held;
    bit            s_acc, s_ov;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk_bus(input int idx, input logic [MW-1:0] val);
        logic [IW-1:0] b;
        b = '0;
        for (int k = 0; k < TM; k++)
            b[IW-1-k*MW -: MW] = (k == idx) ? val : MW'($urandom);
        return b;
    endfunction

    // One cycle: drive at negedge, then account for the handshakes at the next posedge.
    task automatic step(input bit iv, input int idx, input logic [MW-1:0] val,
                        input bit ordy, input bit clr);
        exp_t e;
        @(negedge clk);
        in_valid    = iv;
        slicing_idx = 2'(idx);
        in_data     = mk_bus(idx, val);
        out_ready   = ordy;
        clear       = clr;
        #1;
        if (stall) chk("hold", {out_data, out_pass, out_last}, held);
        stall = out_valid && !out_ready && !clr;
        held  = {out_data, out_pass, out_last};
        s_acc = in_valid && in_ready;
        s_ov  = out_valid;
        if (clr) begin
            q.delete();
            fb.delete();
        end else begin
            if (s_acc) begin
                fb.push_back(val);
                if (fb.size() == DEPTH) begin
                    for (int p = 0; p < RP; p++)
                        for (int i = 0; i < DEPTH; i++)
                            q.push_back('{fb[i], p, (p == RP-1) && (i == DEPTH-1)});
                    fb.delete();
                end
            end
            if (out_valid && out_ready) begin
                pops++;
                if (q.size() == 0) begin
                    chk("spurious", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("data", out_data, e.d);
                    chk("pass", out_pass, e.p);
                    chk("last", out_last, e.l);
                end
            end
        end
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (q.size() != 0 && n < max) begin
            step(0, 0, '0, 1, 0);
            n++;
        end
        chk("drain_done", q.size(), 0);
    endtask

    task automatic fill4(input logic [MW-1:0] base, input int idx, input bit ordy);
        for (int i = 0; i < DEPTH; i++) begin
            step(1, idx, base + MW'(i), ordy, 0);
            chk("fill_acc", s_acc, 1);
        end
    endtask

    initial begin
        int win, vcnt, acc_n, cyc;
        bit seen;

        // reset state
        #3;
        chk("rst_ov", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_pass", out_pass, 0);
        chk("rst_bf", bank_full, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_inrdy", in_ready, 1);

        // fill/drain on slice 1
        pops = 0;
        fill4(32'd10, 1, 0);
        step(0, 0, '0, 0, 0);
        chk("t1_bf_full", bank_full, 2'b01);
        drain(50);
        step(0, 0, '0, 0, 0);
        chk("t1_bf_empty", bank_full, 2'b00);
        chk("t1_pops", pops, 8);

        // continuous stream: no input stall, no output bubble across banks
        pops = 0; seen = 0; win = 0; vcnt = 0;
        for (int c = 0; c < 40; c++) begin
            step(c < 8, c % TM, 32'h100 + c, 1, 0);
            if (c < 8) chk("ovl_inrdy", s_acc, 1);
            if (s_ov) seen = 1;
            if (seen && win < 16) begin
                win++;
                if (s_ov) vcnt++;
            end
        end
        chk("ovl_nobubble", vcnt, 16);
        chk("ovl_pops", pops, 16);
        chk("ovl_empty", q.size(), 0);

        // backpressure with both banks full
        pops = 0;
        for (int i = 0; i < 2 * DEPTH; i++) begin
            step(1, 3 - (i % TM), 32'h200 + i, 0, 0);
            chk("bp_acc", s_acc, 1);
        end
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 32'hDEAD, 0, 0);
            chk("bp_inrdy", s_acc, 0);
            chk("bp_bf", bank_full, 2'b11);
        end
        drain(60);
        chk("bp_pops", pops, 16);

        // random backpressure scoreboard run
        pops = 0; acc_n = 0; cyc = 0;
        while ((acc_n < 1000 || q.size() != 0 || fb.size() != 0) && cyc < 20000) begin
            step((acc_n < 1000) && ($urandom_range(3) != 0), $urandom_range(TM-1),
                 MW'($urandom), $urandom_range(1) == 1, 0);
            if (s_acc) acc_n++;
            cyc++;
        end
        chk("rnd_acc", acc_n, 1000);
        chk("rnd_pops", pops, 2000);

        // clear mid-drain at pass 1 word 2
        pops = 0; cyc = 0;
        fill4(32'd30, 2, 0);
        while (pops < 6 && cyc < 50) begin
            step(0, 0, '0, 1, 0);
            cyc++;
        end
        chk("clr_pops", pops, 6);
        step(0, 0, '0, 1, 1);
        step(0, 0, '0, 0, 0);
        chk("clr_ov", out_valid, 0);
        chk("clr_inrdy", in_ready, 1);
        chk("clr_bf", bank_full, 0);
        pops = 0;
        fill4(32'd40, 0, 0);
        drain(50);
        chk("clr_fresh_pops", pops, 8);

        // asynchronous reset between edges
        fill4(32'd50, 3, 0);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ov", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_last", out_last, 0);
        chk("arst_pass", out_pass, 0);
        chk("arst_bf", bank_full, 0);
        q.delete();
        fb.delete();
        stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
        pops = 0;
        fill4(32'd60, 1, 0);
        drain(50);
        chk("arst_pops", pops, 8);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ping_pong_buffer_ctrl.md
Name: ping_pong_buffer_ctrl

Overview:
Self-controlled two-bank ping-pong buffer between a linear-projection producer and a matmul consumer in multi-head attention. It selects one MODULE_WIDTH slice of a wide multi-module producer bus and fills one bank while the other is drained. Each bank is drained a programmable number of times, for operand reuse, before it is released. Banks are ordered by valid/ready handshakes, so no external bank-enable or address sequencing is needed.

Parameters:
WIDTH, 16, element width in bits
NUM_CORES_A, 2, cores along A per module
NUM_CORES_B, 1, cores along B per module
TOTAL_MODULES, 4, modules packed on in_data, MSB-first
DEPTH, 32, words per bank (COL_X * TOTAL_INPUT_W of producer); must be >= 2
READ_PASSES, 2, full drains of a bank before release; must be >= 1
MODULE_WIDTH, WIDTH*top_pkg::TOP_CHUNK_SIZE*NUM_CORES_A*NUM_CORES_B, localparam, word width
IN_WIDTH, MODULE_WIDTH*TOTAL_MODULES, localparam, producer bus width
ADDR_WIDTH, $clog2(DEPTH), localparam

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous flush of all bank state
slicing_idx  in  $clog2(TOTAL_MODULES)  module select; index 0 = MSB slice; sampled per accepted beat
in_valid  in  1  producer beat valid
in_ready  out  1  buffer can accept a beat
in_data  in  IN_WIDTH  producer bus
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts
out_data  out  MODULE_WIDTH  bank word
out_last  out  1  final word of final pass of the current bank
out_pass  out  $clog2(READ_PASSES+1)  current pass index
bank_full  out  2  per-bank FULL or DRAINING status

Behaviour:
- Single clock, clk; reset asynchronous and active-low (rst_n). All outputs reset to 0; both banks EMPTY; wr_bank=0, rd_bank=0; all counters 0.
- Per-bank state: EMPTY -> FILLING (first accepted write) -> FULL (DEPTH-th write) -> DRAINING (first read issued) -> EMPTY (last word of last pass accepted).
- Write side: in_ready = 1 when bank[wr_bank] is EMPTY or FILLING, and clear is low.
  - Beat accepted when in_valid & in_ready. Write extract_module(in_data, slicing_idx) = in_data[IN_WIDTH-(idx+1)*MODULE_WIDTH +: MODULE_WIDTH] to bank[wr_bank][wr_addr].
  - wr_addr increments by 1. At wr_addr == DEPTH-1: bank goes FULL, wr_addr wraps to 0, wr_bank toggles.
  - slicing_idx >= TOTAL_MODULES: the beat is accepted and dropped, no write or address advance (SVA flags it).
- Read side: RAM has 1-cycle synchronous read. A 2-entry output skid register decouples RAM latency from out_ready.
  - Reads are issued from bank[rd_bank] while it is FULL or DRAINING and the skid has room.
  - rd_addr sweeps 0..DEPTH-1. pass increments on wrap. After READ_PASSES sweeps, no more reads are issued from that bank.
  - The bank becomes EMPTY on the cycle its final word is accepted at out_ready. rd_bank then toggles.
  - Latency: the bank goes FULL at edge N, the first read is issued at N+1, and out_valid rises at N+2.
  - With out_ready held high, throughput is 1 word per cycle, including across pass wraps and bank switches.
- Handshake rules: out_data, out_last and out_pass hold stable while out_valid & !out_ready. in_ready does not combinationally depend on in_valid.
- Simultaneous events:
  - A write completes into bank X in the same cycle a release of bank Y occurs: both take effect.
  - A write into a bank on the same cycle it is released to EMPTY cannot happen, because in_ready gating prevents it.
  - Both banks FULL: in_ready=0 until one bank is released.
- Wrap-around: wr_addr, rd_addr and pass counters wrap exactly at DEPTH-1 / READ_PASSES-1; no off-by-one overrun.
- clear: next edge returns every state, pointer, counter and skid entry to its reset value. Any in-flight output word is discarded and out_valid=0 the next cycle. clear overrides a handshake in the same cycle.
- Reset mid-operation: immediate return to reset values. RAM contents are don't-care and are never read before being rewritten.

Decomposition:
- top_pkg: add typedef bank_state_e {EMPTY, FILLING, FULL, DRAINING}; keep TOP_CHUNK_SIZE and TOP_BLOCK_SIZE there.
- extract_module function moves to top_pkg as a parametrised-width function.
- Sub-module pp_bank_ram: simple dual-port RAM, 1 write port and 1 read port, DEPTH x MODULE_WIDTH, 1-cycle read latency; inferred behaviourally, xpm-replaceable. Instantiated twice.

Test Plan:
- Fill/drain: DEPTH=4, READ_PASSES=2, TOTAL_MODULES=4, slicing_idx=1; write 4 beats with slice1=10,11,12,13 -> out sequence 10,11,12,13,10,11,12,13; out_last only on the 8th word; bank_full=2'b01 then 2'b00.
- Ping-pong overlap: stream 8 beats continuously with out_ready=1 -> in_ready never drops; bank1 fills during bank0 drain; output has no bubble between banks after the first out_valid.
- Backpressure: both banks full, out_ready=0 for 10 cycles -> in_ready=0; out_data stable; no word is lost or duplicated once out_ready=1.
- Random out_ready toggling at 50% over 1000 beats with scoreboard -> order and pass replication are exact; out_pass is 0,1 per bank.
- clear asserted mid-drain, at pass 1 word 2 -> next cycle out_valid=0, in_ready=1, bank_full=0; a new fill reads back fresh data only.
- rst_n pulsed low asynchronously between edges -> all outputs 0 immediately; recovery fill/drain is correct.
